// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit processor and the instruction feeder that drives it.
package cpu_pkg;

    localparam int WORD_W = 9;

    localparam logic [2:0] MV       = 3'b000;
    localparam logic [2:0] MVI      = 3'b001;
    localparam logic [2:0] ADD      = 3'b010;
    localparam logic [2:0] SUB      = 3'b011;
    localparam logic [2:0] SPECIALM = 3'b100;
    localparam logic [2:0] HALT     = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        EXEC   = 2'b10,
        HALTED = 2'b11
    } feeder_state_e;

    function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] w);
        return w[WORD_W-1 -: 3];
    endfunction

    function automatic logic is_halt(input logic [WORD_W-1:0] w);
        return (opcode_of(w) == HALT);
    endfunction

    // MVI carries its immediate in the following word, so it is two words long.
    function automatic logic is_mvi(input logic [WORD_W-1:0] w);
        return (opcode_of(w) == MVI);
    endfunction

endpackage

// File: rtl/instr_feeder_prog_mem.sv
// Program store: DEPTH x 9 register array, synchronous write, combinational read, no reset.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Addresses past DEPTH (non power-of-two depths) are dropped on write and read as zero.
    always_ff @(posedge clk_i) begin
        if (we_i && ({1'b0, waddr_i} < DEPTH_W)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata_o = {WORD_W{1'b0}};
        if ({1'b0, raddr_i} < DEPTH_W) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {WORD_W{1'b0}};
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Program sequencer feeding the 9-bit processor one instruction at a time over Run/DIN/Done,
// stopping on HALT, end of memory, or a Done timeout.
module instr_feeder
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic [AW-1:0]     PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [15:0]       InstrCount
);

    localparam int              TW        = $clog2(TIMEOUT + 1);
    localparam int              LAST_I    = DEPTH - 1;
    localparam logic [AW:0]     DEPTH_W   = DEPTH[AW:0];
    localparam logic [AW-1:0]   LAST_ADDR = LAST_I[AW-1:0];
    localparam logic [AW-1:0]   ONE_A     = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]   TMO_LIMIT = TIMEOUT[TW-1:0];
    localparam logic [TW-1:0]   TMO_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [WORD_W-1:0] ZERO_W  = {WORD_W{1'b0}};

    feeder_state_e     state_q, state_d;
    logic [WORD_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mvi_q, mvi_d;
    logic              busy_q, halted_q;

    logic              mem_we_s;
    logic [AW-1:0]     rd_addr_s;
    logic [WORD_W-1:0] rd_word_s;
    logic [AW:0]       npc_s;
    logic [15:0]       cnt_inc_s;
    logic [TW-1:0]     tmo_inc_s;

    // An MVI in the last slot has no room for its immediate and must not be issued.
    function automatic logic mvi_at_end(input logic [AW-1:0] addr, input logic [WORD_W-1:0] w);
        return is_mvi(w) && (addr == LAST_ADDR);
    endfunction

    assign mem_we_s  = prog_we && ((state_q == IDLE) || (state_q == HALTED));
    assign npc_s     = {1'b0, pc_q} + (mvi_q ? {{(AW-1){1'b0}}, 2'b10} : {{AW{1'b0}}, 1'b1});
    assign cnt_inc_s = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);
    assign tmo_inc_s = tmo_q + TMO_ONE;

    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk_i   (Clock),
        .we_i    (mem_we_s),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (rd_addr_s),
        .rdata_o (rd_word_s)
    );

    // Single read port: word 0 when starting, the immediate during ISSUE, the next PC during EXEC.
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        case (state_q)
            ISSUE:   rd_addr_s = pc_q + ONE_A;
            EXEC:    rd_addr_s = npc_s[AW-1:0];
            default: rd_addr_s = {AW{1'b0}};
        endcase
    end

    // Next-state and next-output logic; Abort overrides everything.
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        run_d   = 1'b0;
        pc_d    = pc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mvi_d   = mvi_q;
        if (Abort) begin
            state_d = IDLE;
            din_d   = ZERO_W;
            tmo_d   = {TW{1'b0}};
        end else begin
            case (state_q)
                IDLE, HALTED: begin
                    din_d = ZERO_W;
                    tmo_d = {TW{1'b0}};
                    if (Start) begin
                        pc_d  = {AW{1'b0}};
                        err_d = 1'b0;
                        cnt_d = 16'd0;
                        if (is_halt(rd_word_s)) begin
                            state_d = HALTED;
                        end else if (mvi_at_end({AW{1'b0}}, rd_word_s)) begin
                            err_d   = 1'b1;
                            state_d = HALTED;
                        end else begin
                            state_d = ISSUE;
                            run_d   = 1'b1;
                            din_d   = rd_word_s;
                            mvi_d   = is_mvi(rd_word_s);
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ISSUE: begin
                    state_d = EXEC;
                    tmo_d   = {TW{1'b0}};
                    if (mvi_q) begin
                        din_d = rd_word_s;
                    end else begin
                        din_d = ZERO_W;
                    end
                end
                EXEC: begin
                    if (Done) begin
                        cnt_d = cnt_inc_s;
                        tmo_d = {TW{1'b0}};
                        if (npc_s >= DEPTH_W) begin
                            state_d = HALTED;
                            pc_d    = LAST_ADDR;
                            din_d   = ZERO_W;
                        end else if (is_halt(rd_word_s)) begin
                            state_d = HALTED;
                            pc_d    = npc_s[AW-1:0];
                            din_d   = ZERO_W;
                        end else if (mvi_at_end(npc_s[AW-1:0], rd_word_s)) begin
                            state_d = HALTED;
                            pc_d    = npc_s[AW-1:0];
                            err_d   = 1'b1;
                            din_d   = ZERO_W;
                        end else begin
                            state_d = ISSUE;
                            pc_d    = npc_s[AW-1:0];
                            run_d   = 1'b1;
                            din_d   = rd_word_s;
                            mvi_d   = is_mvi(rd_word_s);
                        end
                    end else if (tmo_inc_s == TMO_LIMIT) begin
                        state_d = HALTED;
                        err_d   = 1'b1;
                        din_d   = ZERO_W;
                        tmo_d   = {TW{1'b0}};
                    end else begin
                        tmo_d = tmo_inc_s;
                    end
                end
                default: begin
                    state_d = IDLE;
                    din_d   = ZERO_W;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            din_q    <= ZERO_W;
            run_q    <= 1'b0;
            pc_q     <= {AW{1'b0}};
            err_q    <= 1'b0;
            cnt_q    <= 16'd0;
            tmo_q    <= {TW{1'b0}};
            mvi_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            run_q    <= run_d;
            pc_q     <= pc_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            mvi_q    <= mvi_d;
            busy_q   <= (state_d == ISSUE) || (state_d == EXEC);
            halted_q <= (state_d == HALTED);
        end
    end

    assign DIN        = din_q;
    assign Run        = run_q;
    assign PC         = pc_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign Error      = err_q;
    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a small behavioural 9-bit processor on the main instance, a DEPTH=4 instance for end-of-memory cases.
module tb_instr_feeder;

    logic       Clock = 1'b0;
    logic       Resetn, prog_we, Start, Abort, Done, proc_en;
    logic [4:0] prog_addr;
    logic [8:0] prog_data, DIN;
    logic       Run, Busy, Halted, Error;
    logic [4:0] PC;
    logic [15:0] InstrCount;

    logic       prog_we2, Start2, Abort2, done2;
    logic [1:0] prog_addr2, PC2;
    logic [8:0] prog_data2, DIN2;
    logic       Run2, Busy2, Halted2, Error2;
    logic [15:0] InstrCount2;

    int total = 0;
    int bad   = 0;
    int dbl_run = 0;
    int runs2 = 0;
    logic run_prev = 1'b0;

    always #5 Clock = ~Clock;

    instr_feeder dut (
        .Clock(Clock), .Resetn(Resetn), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .Start(Start), .Abort(Abort), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted),
        .Error(Error), .InstrCount(InstrCount)
    );

    instr_feeder #(.DEPTH(4), .AW(2), .TIMEOUT(15)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .prog_we(prog_we2), .prog_addr(prog_addr2),
        .prog_data(prog_data2), .Start(Start2), .Abort(Abort2), .Done(done2),
        .DIN(DIN2), .Run(Run2), .PC(PC2), .Busy(Busy2), .Halted(Halted2),
        .Error(Error2), .InstrCount(InstrCount2)
    );

    // Processor model: MV/MVI finish in T1, ADD/SUB in T3.
    logic [2:0] pstep;
    logic [8:0] ir, reg_a, reg_g;
    logic [8:0] R [8];
    logic [2:0] p_op;
    logic       pdone_s;
    assign p_op    = ir[8:6];
    assign pdone_s = ((pstep == 3'd1) && ((p_op == 3'b000) || (p_op == 3'b001))) ||
                     ((pstep == 3'd3) && ((p_op == 3'b010) || (p_op == 3'b011)));
    assign Done    = proc_en & pdone_s;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            pstep <= 3'd0; ir <= 9'h000; reg_a <= 9'h000; reg_g <= 9'h000;
            for (int i = 0; i < 8; i++) R[i] <= 9'h000;
        end else begin
            case (pstep)
                3'd0: if (Run) begin ir <= DIN; pstep <= 3'd1; end
                3'd1: begin
                    case (p_op)
                        3'b000:  begin R[ir[5:3]] <= R[ir[2:0]]; pstep <= 3'd0; end
                        3'b001:  begin R[ir[5:3]] <= DIN; pstep <= 3'd0; end
                        3'b010, 3'b011: begin reg_a <= R[ir[5:3]]; pstep <= 3'd2; end
                        default: pstep <= 3'd0;
                    endcase
                end
                3'd2: begin
                    reg_g <= (p_op == 3'b011) ? reg_a - R[ir[2:0]] : reg_a + R[ir[2:0]];
                    pstep <= 3'd3;
                end
                3'd3: begin R[ir[5:3]] <= reg_g; pstep <= 3'd0; end
                default: pstep <= 3'd0;
            endcase
        end
    end

    // Small instance answers every instruction with Done one cycle after Run.
    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) done2 <= 1'b0;
        else         done2 <= Run2;
    end

    always @(posedge Clock) begin
        run_prev <= Run;
        if (Run2) runs2 <= runs2 + 1;
    end

    always @(negedge Clock) begin
        if (Run && run_prev) dbl_run <= dbl_run + 1;
    end

    typedef struct {
        logic [6:0][8:0] w;
        int              n;
        logic [8:0]      fill;
        int              cnt;
        int              pc;
        logic            err;
        logic [8:0]      r0;
        logic [8:0]      r2;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input logic [8:0] a0, a1, a2, a3, a4, a5, a6,
                                input int n, input logic [8:0] fill, input int cnt, input int pc,
                                input logic err, input logic [8:0] r0, input logic [8:0] r2);
        vec_t v;
        v.w[0] = a0; v.w[1] = a1; v.w[2] = a2; v.w[3] = a3;
        v.w[4] = a4; v.w[5] = a5; v.w[6] = a6;
        v.n = n; v.fill = fill; v.cnt = cnt; v.pc = pc; v.err = err; v.r0 = r0; v.r2 = r2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic reset_dut;
        Resetn = 1'b0;
        #2;
        Resetn = 1'b1;
    endtask

    task automatic load1(input vec_t v);
        for (int a = 0; a < 32; a++) begin
            prog_we = 1'b1; prog_addr = 5'(a);
            prog_data = (a < v.n) ? v.w[a] : v.fill;
            tick();
        end
        prog_we = 1'b0;
    endtask

    task automatic load2(input logic [8:0] a0, a1, a2, a3);
        logic [3:0][8:0] ws;
        ws[0] = a0; ws[1] = a1; ws[2] = a2; ws[3] = a3;
        for (int a = 0; a < 4; a++) begin
            prog_we2 = 1'b1; prog_addr2 = 2'(a); prog_data2 = ws[a];
            tick();
        end
        prog_we2 = 1'b0;
    endtask

    task automatic start1;
        Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic wait_halt1(input string nm);
        int k = 0;
        while (!Halted && k < 600) begin tick(); k++; end
        check({nm, "_halted"}, Halted, 1);
    endtask

    task automatic wait_add_run(input string nm);
        int k = 0;
        while (!(Run && DIN == 9'h081) && k < 100) begin tick(); k++; end
        check({nm, "_add_run"}, Run, 1);
    endtask

    initial begin
        int k;
        int r_before;
        Resetn = 1'b1; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 9'h000;
        Start = 1'b0; Abort = 1'b0; proc_en = 1'b1;
        prog_we2 = 1'b0; prog_addr2 = 2'd0; prog_data2 = 9'h000; Start2 = 1'b0; Abort2 = 1'b0;
        #1 Resetn = 1'b0;
        #2;
        check("rst_din", DIN, 0);   check("rst_run", Run, 0);   check("rst_pc", PC, 0);
        check("rst_busy", Busy, 0); check("rst_halted", Halted, 0);
        check("rst_err", Error, 0); check("rst_cnt", InstrCount, 0);
        @(posedge Clock); #1 Resetn = 1'b1;

        vecs[0] = mk(9'h040, 9'h005, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 3, 9'h1C0, 1, 2, 1'b0, 9'h005, 9'h000);
        vecs[1] = mk(9'h040, 9'h005, 9'h048, 9'h003, 9'h081, 9'h090, 9'h1C0, 7, 9'h1C0, 4, 6, 1'b0, 9'h008, 9'h008);
        vecs[2] = mk(9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 1, 9'h1C0, 0, 0, 1'b0, 9'h000, 9'h000);
        vecs[3] = mk(9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 0, 9'h000, 32, 31, 1'b0, 9'h000, 9'h000);
        vecs[4] = mk(9'h040, 9'h009, 9'h048, 9'h003, 9'h0C1, 9'h1C0, 9'h1C0, 6, 9'h1C0, 3, 5, 1'b0, 9'h006, 9'h000);
        vecs[5] = mk(9'h040, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 3, 9'h1C0, 1, 2, 1'b0, 9'h1C0, 9'h000);
        vecs[6] = mk(9'h048, 9'h007, 9'h001, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 4, 9'h1C0, 2, 3, 1'b0, 9'h007, 9'h000);

        for (int i = 0; i < 7; i++) begin
            reset_dut();
            load1(vecs[i]);
            start1();
            wait_halt1($sformatf("vec%0d", i));
            check($sformatf("vec%0d_cnt", i), InstrCount, vecs[i].cnt);
            check($sformatf("vec%0d_pc", i), PC, vecs[i].pc);
            check($sformatf("vec%0d_err", i), Error, vecs[i].err);
            check($sformatf("vec%0d_r0", i), R[0], vecs[i].r0);
            check($sformatf("vec%0d_r2", i), R[2], vecs[i].r2);
        end

        // MVI handshake, cycle by cycle
        reset_dut(); load1(vecs[0]); start1();
        check("mvi_run1", Run, 1); check("mvi_din1", DIN, 9'h040);
        tick();
        check("mvi_run2", Run, 0); check("mvi_imm", DIN, 9'h005); check("mvi_done", Done, 1);
        tick();
        check("mvi_halted", Halted, 1); check("mvi_pc", PC, 2); check("mvi_cnt", InstrCount, 1);
        check("mvi_hdin", DIN, 0);

        // Next Run follows the ADD's Run by four cycles (Done in T3)
        reset_dut(); load1(vecs[1]); start1(); wait_add_run("gap");
        k = 0;
        do begin tick(); k++; end while (!Run && k < 20);
        check("add_gap", k, 4); check("add_next_din", DIN, 9'h090);

        // Timeout with Done held low
        reset_dut(); load1(mk(9'h081, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 9'h1C0, 2, 9'h1C0, 0, 0, 1'b0, 9'h0, 9'h0));
        proc_en = 1'b0; start1();
        check("tmo_run", Run, 1);
        repeat (15) tick();
        check("tmo_busy_before", Busy, 1); check("tmo_err_before", Error, 0);
        tick();
        check("tmo_halted", Halted, 1); check("tmo_err", Error, 1); check("tmo_din", DIN, 0);
        proc_en = 1'b1;
        start1();
        check("tmo_err_clr", Error, 0);
        wait_halt1("tmo_rerun"); check("tmo_rerun_cnt", InstrCount, 1);

        // Program writes during EXEC are ignored
        reset_dut(); load1(vecs[1]); start1();
        k = 0;
        while (!(Busy && !Run) && k < 20) begin tick(); k++; end
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 9'h1C0; tick(); prog_we = 1'b0;
        wait_halt1("lock"); check("lock_cnt1", InstrCount, 4);
        start1();
        check("lock_din0", DIN, 9'h040);
        wait_halt1("lock2"); check("lock_cnt2", InstrCount, 4); check("lock_err", Error, 0);

        // Abort coincident with the ADD's Done, then Abort beating Start
        reset_dut(); load1(vecs[1]); start1(); wait_add_run("abort");
        repeat (3) tick();
        check("abort_done_seen", Done, 1);
        Abort = 1'b1; tick(); Abort = 1'b0;
        check("abort_busy", Busy, 0); check("abort_halted", Halted, 0); check("abort_run", Run, 0);
        check("abort_din", DIN, 0); check("abort_cnt", InstrCount, 2); check("abort_pc", PC, 4);
        Abort = 1'b1; Start = 1'b1; tick(); Abort = 1'b0; Start = 1'b0;
        check("abort_vs_start", Busy, 0); check("abort_vs_start_cnt", InstrCount, 2);

        // Asynchronous reset in the middle of EXEC
        reset_dut(); load1(vecs[1]); start1(); wait_add_run("mrst");
        tick();
        Resetn = 1'b0; #1;
        check("mrst_run", Run, 0); check("mrst_din", DIN, 0); check("mrst_pc", PC, 0);
        check("mrst_busy", Busy, 0); check("mrst_cnt", InstrCount, 0);
        tick(); Resetn = 1'b1;
        start1();
        check("mrst_rerun_din", DIN, 9'h040); check("mrst_rerun_pc", PC, 0);
        wait_halt1("mrst_rerun"); check("mrst_rerun_cnt", InstrCount, 4); check("mrst_r0", R[0], 9'h008);

        // DEPTH=4: run off the end, then MVI in the last slot
        reset_dut(); load2(9'h000, 9'h008, 9'h010, 9'h018);
        r_before = runs2;
        Start2 = 1'b1; tick(); Start2 = 1'b0;
        k = 0;
        while (!Halted2 && k < 100) begin tick(); k++; end
        check("eom_halted", Halted2, 1); check("eom_cnt", InstrCount2, 4);
        check("eom_pc", PC2, 3); check("eom_err", Error2, 0); check("eom_runs", runs2 - r_before, 4);
        load2(9'h000, 9'h000, 9'h000, 9'h040);
        r_before = runs2;
        Start2 = 1'b1; tick(); Start2 = 1'b0;
        k = 0;
        while (!Halted2 && k < 100) begin tick(); k++; end
        check("mviend_halted", Halted2, 1); check("mviend_err", Error2, 1);
        check("mviend_runs", runs2 - r_before, 3); check("mviend_cnt", InstrCount2, 3);
        check("mviend_pc", PC2, 3);

        check("run_never_twice", dbl_run, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program sequencer that drives the 9-bit processor's instruction side: DIN and Run out, Done back in.
- Holds a small loadable program memory of 9-bit words.
- Issues one instruction at a time under the processor's Run/Done handshake, including the second (immediate) word for MVI.
- Stops on a HALT word, at end of memory, or when Done does not arrive within a timeout.

Parameters:
- DEPTH, 32: program memory depth in 9-bit words.
- AW, 5: address width, must equal clog2(DEPTH).
- TIMEOUT, 15: maximum EXEC cycles to wait for Done before flagging Error.

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- Resetn  in  1  asynchronous active-low reset; the processor shares the same Resetn.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  AW  program memory write address.
- prog_data  in  9  program memory write data.
- Start  in  1  begin execution at address 0; sampled only in IDLE or HALTED.
- Abort  in  1  synchronous return to IDLE from any state.
- Done  in  1  processor's end-of-instruction indication.
- DIN  out  9  word presented to the processor; registered.
- Run  out  1  one-cycle instruction-issue pulse; registered.
- PC  out  AW  address of the current instruction.
- Busy  out  1  high in ISSUE and EXEC.
- Halted  out  1  high in HALTED.
- Error  out  1  sticky fault flag; cleared by Start or reset.
- InstrCount  out  16  number of instructions retired since the last Start; saturates at 16'hFFFF.

Behaviour:
- Reset: state=IDLE; DIN=0, Run=0, PC=0, Busy=0, Halted=0, Error=0, InstrCount=0, timeout counter=0.
  - Memory contents are not reset.
- Opcode is word[8:6]. Instruction length: MVI (3'b001) is 2 words, all others 1 word. HALT is 3'b111; it is never sent to the processor.
- Memory writes:
  - Accepted only in IDLE or HALTED; ignored in ISSUE and EXEC.
  - Read is combinational from the register array.
- IDLE:
  - Run=0, DIN=0.
  - On Start: PC←0, Error←0, InstrCount←0.
    - If mem[0] is HALT, next state is HALTED.
    - Otherwise next state is ISSUE with Run←1 and DIN←mem[0].
- ISSUE (exactly 1 cycle, Run=1):
  - Next state is EXEC with Run←0.
  - DIN←mem[PC+1] if the opcode is MVI, else DIN←9'h000.
  - Run is never high for 2 consecutive cycles; the processor holds T1 while Run stays high.
- EXEC:
  - Run=0 and DIN is held.
  - For MVI, the immediate is on DIN in the first EXEC cycle, which is when the processor latches it and raises Done.
  - Timeout counter increments each cycle.
  - On Done=1:
    - Set nPC=PC+len and InstrCount←InstrCount+1, then clear the timeout counter.
    - If nPC≥DEPTH, or mem[nPC] is HALT: HALTED, PC←nPC clamped to DEPTH-1, DIN←0.
    - Otherwise: ISSUE, PC←nPC, Run←1, DIN←mem[nPC]. The next Run comes the cycle after Done, when the processor is back in T0.
  - If the timeout counter reaches TIMEOUT without Done: Error←1, HALTED, DIN←0.
- MVI at address DEPTH-1:
  - Detected in IDLE or EXEC before issuing: Error←1, HALTED.
  - The word is not issued.
- HALTED:
  - Run=0, DIN=0, Halted=1.
  - Start restarts exactly as from IDLE.
- Abort:
  - Has priority over every other event, including a coincident Done or Start.
  - Next state is IDLE, Run←0, DIN←0.
  - PC, Error and InstrCount are held.
- Done outside EXEC is ignored.
- Asynchronous reset in any state returns all outputs to their reset values immediately.

Decomposition:
- Shared package cpu_pkg:
  - Opcode constants MV, MVI, ADD, SUB, SPECIALM, HALT (3'b111).
  - Word width 9.
  - Feeder state encoding IDLE, ISSUE, EXEC, HALTED.
- One sub-module: prog_mem. DEPTH×9 register array with synchronous write and combinational read; it needs no reset.

Test Plan:
- MVI+HALT: load {9'h040, 9'h005, 9'h1C0}, pulse Start, processor attached.
  - Required: Run high for 1 cycle with DIN=9'h040; next cycle DIN=9'h005 and Done=1.
  - Then Halted=1, PC=2, InstrCount=1, and processor R0=5.
- Full program: MVI R0,#5; MVI R1,#3; ADD R0,R1 (9'h081); MV R2,R0 (9'h090); HALT.
  - Required: R0=8, R2=8, InstrCount=4, Error=0.
  - ADD Done arrives 3 cycles after its Run.
- Timeout: load {9'h081, HALT}, Done tied low.
  - Required: Error=1 and Halted=1 exactly TIMEOUT EXEC cycles after Run.
- End of memory: DEPTH=4, load 4 MV words, no HALT.
  - Required: 4 retirements, then Halted=1, PC=3, Error=0.
  - Separately, an MVI at address 3 gives Error=1 with no Run issued for it.
- Abort and write lockout:
  - Assert Abort in the same cycle as Done during the ADD: required IDLE, InstrCount unchanged.
  - prog_we during EXEC: required the memory is unchanged.
- Reset mid-EXEC: drop Resetn.
  - Required: Run=0, DIN=0, PC=0, Busy=0 asynchronously.
  - A following Start runs from address 0.
